// File: rtl/multiplicador_sinal.sv
// Sequential shift-add multiplier, N x N -> 2N, signed or unsigned per operation.
// One partial product per clock; start/busy/done handshake with the result held until the next accept.
module multiplicador_sinal #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   B_in,
  input  logic [N-1:0]   Q_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P_out
);
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [N:0]       a_q;
  logic [N-1:0]     b_q, q_q;
  logic             sgn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [2*N-1:0]   p_q;

  logic [N+1:0]     a_ext, b_ext, sum_d;
  logic             last;

  // Sum is kept two bits wider than the accumulator so its top bit is the true
  // sign (signed) or the carry (unsigned) that enters on the shift.
  always_comb begin
    last  = (cnt_q == LAST);
    b_ext = sgn_q ? {{2{b_q[N-1]}}, b_q} : {2'b00, b_q};
    a_ext = {sgn_q & a_q[N], a_q};
    sum_d = a_ext;
    if (q_q[0]) begin
      if (sgn_q && last) sum_d = a_ext - b_ext;
      else               sum_d = a_ext + b_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            b_q     <= B_in;
            q_q     <= Q_in;
            sgn_q   <= signed_mode;
            a_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q   <= sum_d[N+1:1];
          q_q   <= {sum_d[0], q_q[N-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            // Same bits that land in {A[N-1:0],Q} after this final shift.
            p_q     <= {sum_d[N:0], q_q[N-1:1]};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign P_out = p_q;

endmodule
